// File: rtl/pl_hazard_mem_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, ResultSrc and forward-select encodings.
package pl_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

endpackage

// File: rtl/pl_hazard_mem_ctrl_if.sv
// Data-memory request handshake between the pipeline sequencer and the data memory.
interface pl_hazard_mem_ctrl_if;
    logic dmem_req;
    logic dmem_ready;

    modport master (output dmem_req, input dmem_ready);
    modport slave  (input dmem_req, output dmem_ready);
endinterface

// File: rtl/pl_hazard_mem_ctrl_forward.sv
// Forward-select for one Execute-stage source operand; Memory stage beats Writeback.
module pl_forward_unit
    import pl_ctrl_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] Forward
);

    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == RsE))
            Forward = FWD_MEM;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE))
            Forward = FWD_WB;
    end

endmodule

// File: rtl/pl_hazard_mem_ctrl.sv
// Pipeline sequencer: hazard stalls/flushes, operand forwarding and the variable-latency
// data-memory handshake with timeout and stall-cycle counter.
module pl_hazard_mem_ctrl
    import pl_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteW,
    pl_hazard_mem_ctrl_if.master dmem,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             memAccM;
    logic             timeoutHit;
    logic             reqRaw;
    logic             memStall;
    logic             lwStall;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;

    assign memAccM    = (ResultSrcM == RES_MEM) | MemWriteM;
    assign timeoutHit = (state == WAIT) & ~dmem.dmem_ready & (wait_cnt == TIMEOUT_C);
    assign reqRaw     = (state == IDLE) ? memAccM : ~timeoutHit;
    assign memStall   = ~rst & reqRaw & ~dmem.dmem_ready;
    assign lwStall    = (ResultSrcE == RES_MEM) & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    pl_forward_unit u_fwd_a (
        .RsE(Rs1E), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .Forward(fwdA)
    );

    pl_forward_unit u_fwd_b (
        .RsE(Rs2E), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .Forward(fwdB)
    );

    // A memory stall freezes everything up to EX/MEM and masks the branch/load-use
    // flushes; a pending PCSrcE flush is then applied on the release cycle.
    always_comb begin
        dmem.dmem_req = ~rst & reqRaw;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushW        = 1'b0;
        ForwardAE     = FWD_RF;
        ForwardBE     = FWD_RF;
        if (!rst) begin
            ForwardAE = fwdA;
            ForwardBE = fwdB;
            if (memStall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lwStall;
                StallD = lwStall;
                FlushE = lwStall | PCSrcE;
                FlushD = PCSrcE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (memStall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            case (state)
                IDLE: begin
                    if (memStall) begin
                        state    <= WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (dmem.dmem_ready) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (timeoutHit) begin
                        state       <= IDLE;
                        wait_cnt    <= '0;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
